// File: rtl/bcd_time_counter.sv
// MM:SS BCD time counter with adjust, pause toggle, clear and rollover pulse.
// Optional COUNTDOWN_EN adds load, count-down and done.
//
// Ports:
//   clk        system clock, all state on posedge
//   rst        synchronous reset, active-low
//   tick_cnt   1-cycle count enable
//   tick_adj   1-cycle adjust enable
//   adj        1 = adjust mode
//   sel        adjust field: 0 = seconds, 1 = minutes
//   pause_btn  debounced pause level, rising edge toggles pause
//   clr        synchronous clear of time digits
//   dir_down   (COUNTDOWN_EN) 1 = count down in normal mode
//   load       (COUNTDOWN_EN) copy load_min/load_sec, clamped
//   load_min   (COUNTDOWN_EN) minutes to load, BCD
//   load_sec   (COUNTDOWN_EN) seconds to load, BCD
//   done       (COUNTDOWN_EN) 1-cycle pulse on reaching 00:00
//   min_bcd    minutes, BCD, digit 0 in [3:0]
//   sec_bcd    seconds, BCD, tens in [7:4]
//   paused     1 = counting frozen
//   wrap       1-cycle pulse on MIN_TOP:59 -> 00:00
module bcd_time_counter #(
  parameter int MIN_DIGITS = 2,
  parameter int MIN_TOP    = 99
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick_cnt,
  input  logic                    tick_adj,
  input  logic                    adj,
  input  logic                    sel,
  input  logic                    pause_btn,
  input  logic                    clr,
`ifdef COUNTDOWN_EN
  input  logic                    dir_down,
  input  logic                    load,
  input  logic [4*MIN_DIGITS-1:0] load_min,
  input  logic [7:0]              load_sec,
  output logic                    done,
`endif
  output logic [4*MIN_DIGITS-1:0] min_bcd,
  output logic [7:0]              sec_bcd,
  output logic                    paused,
  output logic                    wrap
);

  localparam int MW = 4 * MIN_DIGITS;

  function automatic logic [MW-1:0] to_bcd(
    input int v
  );
    int          t;
    logic [MW-1:0] r;
    t = v;
    r = '0;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [MW-1:0] TOP_BCD = to_bcd(MIN_TOP);

  // Ripple BCD increment across all minute digits.
  function automatic logic [MW-1:0] min_inc(
    input logic [MW-1:0] v
  );
    logic [MW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] sec_inc(
    input logic [7:0] s
  );
    if (s == 8'h59)
      return 8'h00;
    if (s[3:0] == 4'd9)
      return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

`ifdef COUNTDOWN_EN
  // Ripple BCD decrement; only called with a non-zero value.
  function automatic logic [MW-1:0] min_dec(
    input logic [MW-1:0] v
  );
    logic [MW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] sec_dec(
    input logic [7:0] s
  );
    if (s == 8'h00)
      return 8'h59;
    if (s[3:0] == 4'd0)
      return {s[7:4] - 4'd1, 4'd9};
    return {s[7:4], s[3:0] - 4'd1};
  endfunction

  function automatic logic [3:0] dig_clamp(
    input logic [3:0] d
  );
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Digits are made legal first, so a packed compare
  // against the BCD limit orders the values numerically.
  function automatic logic [MW-1:0] min_clamp(
    input logic [MW-1:0] v
  );
    logic [MW-1:0] r;
    for (int i = 0; i < MIN_DIGITS; i++)
      r[4*i +: 4] = dig_clamp(v[4*i +: 4]);
    return (r > TOP_BCD) ? TOP_BCD : r;
  endfunction

  function automatic logic [7:0] sec_clamp(
    input logic [7:0] s
  );
    logic [7:0] r;
    r = {dig_clamp(s[7:4]), dig_clamp(s[3:0])};
    return (r > 8'h59) ? 8'h59 : r;
  endfunction
`endif

  logic [MW-1:0] r_min;
  logic [7:0]    r_sec;
  logic          r_paused;
  logic          r_pause_q;
  logic          r_wrap;
  logic          r_done;

  logic [MW-1:0] w_min_nxt;
  logic [7:0]    w_sec_nxt;
  logic          w_wrap_nxt;
  logic          w_done_nxt;
  logic          w_run;
  logic          w_toggle;

  assign w_toggle = pause_btn & ~r_pause_q;
  // Uses the registered pause state, so a tick coincident
  // with a toggle sees the old value.
  assign w_run    = tick_cnt & ~r_paused & ~adj;

  always_comb begin
    w_min_nxt  = r_min;
    w_sec_nxt  = r_sec;
    w_wrap_nxt = 1'b0;
    w_done_nxt = 1'b0;
    if (clr) begin
      w_min_nxt = '0;
      w_sec_nxt = '0;
    end
`ifdef COUNTDOWN_EN
    else if (load) begin
      w_min_nxt = min_clamp(load_min);
      w_sec_nxt = sec_clamp(load_sec);
    end
`endif
    else if (adj) begin
      if (tick_adj) begin
        if (sel)
          w_min_nxt = (r_min == TOP_BCD) ? '0
                                         : min_inc(r_min);
        else
          w_sec_nxt = sec_inc(r_sec);
      end
    end
`ifdef COUNTDOWN_EN
    else if (w_run && dir_down) begin
      // 00:00 is terminal: hold, no underflow, no repeat pulse.
      if (r_sec != 8'h00 || r_min != '0) begin
        w_sec_nxt = sec_dec(r_sec);
        if (r_sec == 8'h00)
          w_min_nxt = min_dec(r_min);
        w_done_nxt = (r_min == '0) && (r_sec == 8'h01);
      end
    end
`endif
    else if (w_run) begin
      w_sec_nxt = sec_inc(r_sec);
      if (r_sec == 8'h59) begin
        if (r_min == TOP_BCD) begin
          w_min_nxt  = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_min_nxt = min_inc(r_min);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_min     <= '0;
      r_sec     <= '0;
      r_paused  <= 1'b0;
      r_pause_q <= 1'b0;
      r_wrap    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_min     <= w_min_nxt;
      r_sec     <= w_sec_nxt;
      r_pause_q <= pause_btn;
      r_wrap    <= w_wrap_nxt;
      r_done    <= w_done_nxt;
      if (w_toggle)
        r_paused <= ~r_paused;
    end
  end

  assign min_bcd = r_min;
  assign sec_bcd = r_sec;
  assign paused  = r_paused;
  assign wrap    = r_wrap;
`ifdef COUNTDOWN_EN
  assign done    = r_done;
`else
  logic w_done_unused;
  assign w_done_unused = r_done ^ w_done_nxt;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter, default and 3-digit builds.
module tb_bcd_time_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_cnt, tick_adj, adj, sel;
  logic        pause_btn, clr;
  logic [7:0]  min_bcd;
  logic [7:0]  sec_bcd;
  logic        paused, wrap;

  logic        tick_cnt3, tick_adj3, adj3, sel3;
  logic [11:0] min3;
  logic [7:0]  sec3;
  logic        paused3, wrap3;

`ifdef COUNTDOWN_EN
  logic        dir_down, load, done, done3;
  logic [7:0]  load_min, load_sec;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bcd_time_counter u_dut (
    .clk       (clk),
    .rst       (rst),
    .tick_cnt  (tick_cnt),
    .tick_adj  (tick_adj),
    .adj       (adj),
    .sel       (sel),
    .pause_btn (pause_btn),
    .clr       (clr),
`ifdef COUNTDOWN_EN
    .dir_down  (dir_down),
    .load      (load),
    .load_min  (load_min),
    .load_sec  (load_sec),
    .done      (done),
`endif
    .min_bcd   (min_bcd),
    .sec_bcd   (sec_bcd),
    .paused    (paused),
    .wrap      (wrap)
  );

  bcd_time_counter #(
    .MIN_DIGITS (3),
    .MIN_TOP    (599)
  ) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .tick_cnt  (tick_cnt3),
    .tick_adj  (tick_adj3),
    .adj       (adj3),
    .sel       (sel3),
    .pause_btn (pause_btn),
    .clr       (clr),
`ifdef COUNTDOWN_EN
    .dir_down  (1'b0),
    .load      (1'b0),
    .load_min  (12'h000),
    .load_sec  (8'h00),
    .done      (done3),
`endif
    .min_bcd   (min3),
    .sec_bcd   (sec3),
    .paused    (paused3),
    .wrap      (wrap3)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got %h exp %h", tag, got, exp);
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic adj_ticks(input logic s, input int n);
    adj = 1'b1; sel = s; tick_adj = 1'b1;
    run(n);
    tick_adj = 1'b0;
  endtask

  task automatic adj3_ticks(input logic s, input int n);
    adj3 = 1'b1; sel3 = s; tick_adj3 = 1'b1;
    run(n);
    tick_adj3 = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    tick_cnt = 1'b1; tick_adj = 1'b1;
    adj = 1'b0; sel = 1'b0;
    pause_btn = 1'b0; clr = 1'b0;
    tick_cnt3 = 1'b1; tick_adj3 = 1'b1;
    adj3 = 1'b0; sel3 = 1'b0;
`ifdef COUNTDOWN_EN
    dir_down = 1'b0; load = 1'b0;
    load_min = 8'h00; load_sec = 8'h00;
`endif
    run(2);
    check("rst_min", 32'(min_bcd), 32'h0);
    check("rst_sec", 32'(sec_bcd), 32'h0);
    check("rst_paused", 32'(paused), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_min3", 32'(min3), 32'h0);

    rst = 1'b1;
    tick_adj = 1'b0; tick_cnt3 = 1'b0; tick_adj3 = 1'b0;
    run(10);
    tick_cnt = 1'b0;
    check("cnt10_sec", 32'(sec_bcd), 32'h10);
    check("cnt10_min", 32'(min_bcd), 32'h00);
    tick_cnt = 1'b1;
    run(1);
    tick_cnt = 1'b0;
    check("cnt11_sec", 32'(sec_bcd), 32'h11);

    adj_ticks(1'b0, 48);
    check("adjs_59", 32'(sec_bcd), 32'h59);
    adj_ticks(1'b0, 1);
    check("adjs_wrap_sec", 32'(sec_bcd), 32'h00);
    check("adjs_wrap_min", 32'(min_bcd), 32'h00);
    tick_cnt = 1'b1;
    run(1);
    tick_cnt = 1'b0;
    check("adj_ign_cnt", 32'(sec_bcd), 32'h00);

    adj_ticks(1'b1, 99);
    adj_ticks(1'b0, 59);
    check("pre_min", 32'(min_bcd), 32'h99);
    check("pre_sec", 32'(sec_bcd), 32'h59);
    adj_ticks(1'b1, 1);
    check("adjm_wrap_min", 32'(min_bcd), 32'h00);
    check("adjm_wrap_sec", 32'(sec_bcd), 32'h59);
    check("adjm_no_wrap", 32'(wrap), 32'h0);
    adj_ticks(1'b1, 99);
    adj = 1'b0;
    tick_cnt = 1'b1;
    run(1);
    tick_cnt = 1'b0;
    check("roll_min", 32'(min_bcd), 32'h00);
    check("roll_sec", 32'(sec_bcd), 32'h00);
    check("roll_wrap", 32'(wrap), 32'h1);
    run(1);
    check("roll_wrap_off", 32'(wrap), 32'h0);

    adj_ticks(1'b1, 9);
    adj_ticks(1'b0, 59);
    adj = 1'b0;
    tick_cnt = 1'b1;
    run(1);
    tick_cnt = 1'b0;
    check("carry_min", 32'(min_bcd), 32'h10);
    check("carry_sec", 32'(sec_bcd), 32'h00);

    pause_btn = 1'b1; tick_cnt = 1'b1;
    run(20);
    pause_btn = 1'b0;
    check("pause_on", 32'(paused), 32'h1);
    check("pause_sec", 32'(sec_bcd), 32'h01);
    run(2);
    tick_cnt = 1'b0;
    check("pause_hold", 32'(sec_bcd), 32'h01);
    adj_ticks(1'b0, 1);
    adj = 1'b0;
    check("pause_adj", 32'(sec_bcd), 32'h02);
    pause_btn = 1'b1; tick_cnt = 1'b1;
    run(1);
    pause_btn = 1'b0;
    check("resume_off", 32'(paused), 32'h0);
    check("resume_sec", 32'(sec_bcd), 32'h02);
    run(1);
    tick_cnt = 1'b0;
    check("resume_cnt", 32'(sec_bcd), 32'h03);

    clr = 1'b1; tick_cnt = 1'b1;
    run(1);
    clr = 1'b0; tick_cnt = 1'b0;
    check("clr_min", 32'(min_bcd), 32'h00);
    check("clr_sec", 32'(sec_bcd), 32'h00);
    check("clr_paused", 32'(paused), 32'h0);

`ifdef COUNTDOWN_EN
    load = 1'b1; load_min = 8'h01; load_sec = 8'h75;
    run(1);
    check("ld_clamp_sec", 32'(sec_bcd), 32'h59);
    check("ld_min", 32'(min_bcd), 32'h01);
    load_min = 8'hA5; load_sec = 8'h3C;
    run(1);
    check("ld_nbcd_min", 32'(min_bcd), 32'h95);
    check("ld_nbcd_sec", 32'(sec_bcd), 32'h39);
    load_min = 8'h01; load_sec = 8'h00;
    run(1);
    load = 1'b0;
    dir_down = 1'b1; tick_cnt = 1'b1;
    run(59);
    check("dn_sec01", 32'(sec_bcd), 32'h01);
    check("dn_min00", 32'(min_bcd), 32'h00);
    check("dn_done0", 32'(done), 32'h0);
    run(1);
    check("dn_zero", 32'({min_bcd, sec_bcd}), 32'h0000);
    check("dn_done", 32'(done), 32'h1);
    run(3);
    check("dn_hold", 32'({min_bcd, sec_bcd}), 32'h0000);
    check("dn_done_once", 32'(done), 32'h0);
    check("dn_no_wrap", 32'(wrap), 32'h0);
    tick_cnt = 1'b0; dir_down = 1'b0;
`endif

    adj3_ticks(1'b1, 599);
    adj3_ticks(1'b0, 59);
    check("d3_pre_min", 32'(min3), 32'h599);
    adj3 = 1'b0;
    tick_cnt3 = 1'b1;
    run(1);
    tick_cnt3 = 1'b0;
    check("d3_roll", 32'({min3, sec3}), 32'h00000);
    check("d3_wrap", 32'(wrap3), 32'h1);
    adj3_ticks(1'b1, 9);
    adj3_ticks(1'b0, 59);
    adj3 = 1'b0;
    tick_cnt3 = 1'b1;
    run(1);
    tick_cnt3 = 1'b0;
    check("d3_carry", 32'({min3, sec3}), 32'h01000);
    check("d3_no_wrap", 32'(wrap3), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
